// File: rtl/tail_light_decoder.sv
// Receive-side monitor for the six Thunderbird tail-light lines.
// Tracks each side's animation and hold state, then decodes turn, hazard and brake requests and flags faults.
module tail_light_decoder #(
    parameter int unsigned LOCK_STEPS  = 4,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned FAULT_CNT_W = 8
) (
    input  logic                   CLK,
    input  logic                   RST_n,
    input  logic [2:0]             L_Light,
    input  logic [2:0]             R_Light,
    output logic                   turn_left,
    output logic                   turn_right,
    output logic                   hazard,
    output logic                   brake,
    output logic                   fault,
    output logic [FAULT_CNT_W-1:0] fault_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCKING = 2'd1,
        ANIM    = 2'd2,
        STEADY  = 2'd3
    } trk_state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_STEPS);
    localparam logic [3:0] HOLD_N = 4'(HOLD_CYCLES);

    trk_state_t             r_state [2];
    logic [2:0]             r_prev  [2];
    logic [3:0]             r_step  [2];
    logic [3:0]             r_hold  [2];
    logic                   r_turn_left;
    logic                   r_turn_right;
    logic                   r_hazard;
    logic                   r_brake;
    logic                   r_fault;
    logic [FAULT_CNT_W-1:0] r_fault_cnt;

    trk_state_t w_next_state [2];
    logic [3:0] w_next_step  [2];
    logic [3:0] w_next_hold  [2];
    logic       w_side_fault [2];
    logic [2:0] w_sample     [2];
    logic       w_legal      [2];
    logic       w_is_succ    [2];
    logic [3:0] w_hold_inc   [2];
    logic [3:0] w_step_inc   [2];
    logic       w_both_anim;
    logic       w_hazard;
    logic       w_turn_left;
    logic       w_turn_right;
    logic       w_brake;
    logic       w_fault;

    function automatic logic is_legal(input logic [2:0] c);
        return (c == 3'b000) || (c == 3'b001) || (c == 3'b011) || (c == 3'b111);
    endfunction

    function automatic logic [2:0] successor(input logic [2:0] c);
        case (c)
            3'b000:  return 3'b001;
            3'b001:  return 3'b011;
            3'b011:  return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    assign w_sample[0] = L_Light;
    assign w_sample[1] = R_Light;

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            w_legal[i]    = is_legal(w_sample[i]);
            // An illegal previous code has no successor, so re-locking always restarts from scratch.
            w_is_succ[i]  = is_legal(r_prev[i]) && (w_sample[i] == successor(r_prev[i]));
            w_hold_inc[i] = (r_hold[i] == 4'hF) ? 4'hF : r_hold[i] + 4'd1;
            w_step_inc[i] = (r_step[i] == 4'hF) ? 4'hF : r_step[i] + 4'd1;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            w_next_state[i] = r_state[i];
            w_next_step[i]  = r_step[i];
            w_next_hold[i]  = '0;
            w_side_fault[i] = 1'b0;
            if (!w_legal[i]) begin
                w_next_state[i] = IDLE;
                w_next_step[i]  = '0;
                w_side_fault[i] = 1'b1;
            end else begin
                if (w_sample[i] == 3'b111) w_next_hold[i] = w_hold_inc[i];
                if (w_is_succ[i]) begin
                    if (r_state[i] != ANIM) begin
                        w_next_step[i]  = w_step_inc[i];
                        w_next_state[i] = (w_step_inc[i] >= LOCK_N) ? ANIM : LOCKING;
                    end
                end else begin
                    w_next_step[i] = '0;
                    if (w_sample[i] == 3'b000) begin
                        w_next_state[i] = IDLE;
                    end else if (w_sample[i] == 3'b111) begin
                        w_next_state[i] = (w_hold_inc[i] >= HOLD_N) ? STEADY : LOCKING;
                    end else begin
                        w_next_state[i] = LOCKING;
                        if (r_state[i] == ANIM) w_side_fault[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_both_anim  = (w_next_state[0] == ANIM) && (w_next_state[1] == ANIM);
        w_hazard     = w_both_anim && (L_Light == R_Light);
        w_turn_left  = (w_next_state[0] == ANIM) && (w_next_state[1] != ANIM);
        w_turn_right = (w_next_state[1] == ANIM) && (w_next_state[0] != ANIM);
        w_brake      = ((w_next_state[0] == STEADY) || (w_next_state[1] == STEADY)) && !w_hazard;
        w_fault      = w_side_fault[0] || w_side_fault[1] || (w_both_anim && (L_Light != R_Light));
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_state[i] <= IDLE;
                r_prev[i]  <= '0;
                r_step[i]  <= '0;
                r_hold[i]  <= '0;
            end
            r_turn_left  <= 1'b0;
            r_turn_right <= 1'b0;
            r_hazard     <= 1'b0;
            r_brake      <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_cnt  <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_state[i] <= w_next_state[i];
                r_prev[i]  <= w_sample[i];
                r_step[i]  <= w_next_step[i];
                r_hold[i]  <= w_next_hold[i];
            end
            r_turn_left  <= w_turn_left;
            r_turn_right <= w_turn_right;
            r_hazard     <= w_hazard;
            r_brake      <= w_brake;
            r_fault      <= w_fault;
            if (w_fault && (r_fault_cnt != '1)) r_fault_cnt <= r_fault_cnt + FAULT_CNT_W'(1);
        end
    end

    assign turn_left   = r_turn_left;
    assign turn_right  = r_turn_right;
    assign hazard      = r_hazard;
    assign brake       = r_brake;
    assign fault       = r_fault;
    assign fault_count = r_fault_cnt;

endmodule

// File: tb/tb_tail_light_decoder.sv
// Scoreboard bench for tail_light_decoder: directed scenarios plus random lamp traffic
// checked against a sequence-index reference model.
module tb_tail_light_decoder;

    localparam int LS = 4;
    localparam int HC = 2;
    localparam int FW = 2;
    localparam int FC_MAX = (1 << FW) - 1;

    localparam int M_IDLE = 0;
    localparam int M_LOCK = 1;
    localparam int M_ANIM = 2;
    localparam int M_STDY = 3;

    logic          CLK = 1'b0;
    logic          RST_n;
    logic [2:0]    L_Light;
    logic [2:0]    R_Light;
    logic          turn_left;
    logic          turn_right;
    logic          hazard;
    logic          brake;
    logic          fault;
    logic [FW-1:0] fault_count;

    tail_light_decoder #(
        .LOCK_STEPS  (LS),
        .HOLD_CYCLES (HC),
        .FAULT_CNT_W (FW)
    ) dut (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .L_Light     (L_Light),
        .R_Light     (R_Light),
        .turn_left   (turn_left),
        .turn_right  (turn_right),
        .hazard      (hazard),
        .brake       (brake),
        .fault       (fault),
        .fault_count (fault_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit tl;
        bit tr;
        bit hz;
        bit br;
        bit ft;
        int fc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int m_st[2];
    int m_prev[2];
    int m_step[2];
    int m_hold[2];
    int m_fc;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endfunction

    // Position of a code in the lamp animation 000,001,011,111; -1 when illegal.
    function automatic int seq_pos(input int code);
        int seq[4] = '{0, 1, 3, 7};
        for (int k = 0; k < 4; k++) if (seq[k] == code) return k;
        return -1;
    endfunction

    function automatic int seq_code(input int pos);
        int seq[4] = '{0, 1, 3, 7};
        return seq[pos % 4];
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 2; s++) begin
            m_st[s] = M_IDLE; m_prev[s] = 0; m_step[s] = 0; m_hold[s] = 0;
        end
        m_fc = 0;
    endfunction

    function automatic exp_t model_step(input int l, input int r);
        exp_t e;
        int smp[2];
        bit f;
        bit both;
        smp[0] = l; smp[1] = r;
        f = 0;
        for (int s = 0; s < 2; s++) begin
            int pp = seq_pos(m_prev[s]);
            int np = seq_pos(smp[s]);
            if (np < 0) begin
                m_st[s] = M_IDLE; m_step[s] = 0; m_hold[s] = 0; f = 1;
            end else begin
                bit nxt = (pp >= 0) && (np == (pp + 1) % 4);
                m_hold[s] = (smp[s] == 7) ? ((m_hold[s] < 15) ? m_hold[s] + 1 : 15) : 0;
                if (nxt) begin
                    if (m_st[s] != M_ANIM) begin
                        m_step[s]++;
                        m_st[s] = (m_step[s] >= LS) ? M_ANIM : M_LOCK;
                    end
                end else begin
                    m_step[s] = 0;
                    if (smp[s] == 0) m_st[s] = M_IDLE;
                    else if (smp[s] == 7) m_st[s] = (m_hold[s] >= HC) ? M_STDY : M_LOCK;
                    else begin
                        if (m_st[s] == M_ANIM) f = 1;
                        m_st[s] = M_LOCK;
                    end
                end
            end
            m_prev[s] = smp[s];
        end
        both = (m_st[0] == M_ANIM) && (m_st[1] == M_ANIM);
        e.hz = both && (l == r);
        if (both && (l != r)) f = 1;
        e.tl = (m_st[0] == M_ANIM) && !both;
        e.tr = (m_st[1] == M_ANIM) && !both;
        e.br = ((m_st[0] == M_STDY) || (m_st[1] == M_STDY)) && !e.hz;
        e.ft = f;
        if (f && m_fc < FC_MAX) m_fc++;
        e.fc = m_fc;
        return e;
    endfunction

    task automatic drive(input int l, input int r);
        @(negedge CLK);
        L_Light = 3'(l);
        R_Light = 3'(r);
        sb.push_back(model_step(l, r));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_turn_left"}, int'(turn_left), 0);
        check({tag, "_turn_right"}, int'(turn_right), 0);
        check({tag, "_hazard"}, int'(hazard), 0);
        check({tag, "_brake"}, int'(brake), 0);
        check({tag, "_fault"}, int'(fault), 0);
        check({tag, "_fault_count"}, int'(fault_count), 0);
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RST_n = 1'b0;
        L_Light = '0;
        R_Light = '0;
        model_reset();
        #1;
        check_zero("reset");
        @(negedge CLK);
        RST_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("turn_left", int'(turn_left), int'(e.tl));
                check("turn_right", int'(turn_right), int'(e.tr));
                check("hazard", int'(hazard), int'(e.hz));
                check("brake", int'(brake), int'(e.br));
                check("fault", int'(fault), int'(e.ft));
                check("fault_count", int'(fault_count), e.fc);
            end
        end
    end

    initial begin : stimulus
        int ph[2];
        int mode[2];
        int len;
        RST_n = 1'b0;
        L_Light = '0;
        R_Light = '0;
        model_reset();
        apply_reset();

        // Left turn
        for (int k = 1; k <= 5; k++) drive(seq_code(k), 0);
        apply_reset();
        // Brake on both sides, then release
        for (int k = 0; k < 3; k++) drive(7, 7);
        drive(0, 0);
        apply_reset();
        // Right turn while left holds brake
        for (int k = 1; k <= 5; k++) drive(7, seq_code(k));
        apply_reset();
        // Hazard, then right side skips a step
        for (int k = 1; k <= 6; k++) drive(seq_code(k), seq_code(k));
        drive(seq_code(7), seq_code(8));
        drive(seq_code(8), seq_code(9));
        apply_reset();
        // Illegal code while left is animating, then re-lock
        for (int k = 1; k <= 5; k++) drive(seq_code(k), 0);
        drive(5, 0);
        for (int k = 0; k <= 5; k++) drive(seq_code(k), 0);
        apply_reset();
        // Fault counter saturation
        for (int k = 0; k < 5; k++) drive((k % 2) ? 2 : 5, 0);
        apply_reset();
        // Asynchronous reset in the middle of a hazard
        for (int k = 1; k <= 5; k++) drive(seq_code(k), seq_code(k));
        @(posedge CLK);
        #3;
        RST_n = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        L_Light = '0;
        R_Light = '0;
        @(negedge CLK);
        RST_n = 1'b1;
        for (int k = 1; k <= 5; k++) drive(seq_code(k), seq_code(k));

        // Random traffic: per-side modes animate / hold 111 / random code / dark
        ph[0] = 0; ph[1] = 0;
        for (int b = 0; b < 80; b++) begin
            if (b % 20 == 19) apply_reset();
            len = int'($urandom_range(2, 9));
            mode[0] = int'($urandom_range(0, 3));
            mode[1] = ($urandom_range(0, 2) == 0) ? 4 : int'($urandom_range(0, 3));
            if (mode[1] == 4) ph[1] = ph[0];
            for (int c = 0; c < len; c++) begin
                int v[2];
                for (int s = 0; s < 2; s++) begin
                    int md = (mode[s] == 4) ? mode[0] : mode[s];
                    case (md)
                        0: begin ph[s]++; v[s] = seq_code(ph[s]); end
                        1: v[s] = 7;
                        2: v[s] = int'($urandom_range(0, 7));
                        default: v[s] = ($urandom_range(0, 7) == 0) ? 7 : 0;
                    endcase
                end
                if (mode[1] == 4 && mode[0] != 0) v[1] = v[0];
                drive(v[0], v[1]);
            end
        end

        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge CLK);
        #2;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
